// File: rtl/riscv_pipe_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pipe_pkg
// Shared pipeline definitions for the ID/EX stage slice.
//   ctrl_t        : packed control bundle
//                   {reg_w, mem_read, mem_write, mem_to_reg, alu_src, alu_op[3:0]}
//   CTRL_W        : width of the control bundle in bits
//   CTRL_NOP      : all-zero control bundle used for pipeline bubbles
//   REG_IDX_W     : register index width
//   MEM_READ_BIT  : bit position of mem_read inside a flattened bundle
//   ctrl_mem_read : extracts mem_read from a flattened bundle
// ---------------------------------------------------------------------------
package riscv_pipe_pkg;

   typedef struct packed {
      logic       reg_w;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       alu_src;
      logic [3:0] alu_op;
   } ctrl_t;

   localparam int    CTRL_W       = $bits(ctrl_t);
   localparam ctrl_t CTRL_NOP     = '0;
   localparam int    REG_IDX_W    = 5;
   localparam int    MEM_READ_BIT = CTRL_W - 2;

   // mem_read sits just below reg_w in the flattened bundle.
   function automatic logic ctrl_mem_read(input logic [CTRL_W-1:0] c);
      return c[MEM_READ_BIT];
   endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Combinational load-use hazard detection between the instruction sitting in
// EX (held in the ID/EX register) and the instruction currently in ID.
// Ports:
//   ex_valid, ex_mem_read, ex_rd : state of the instruction in EX
//   id_valid, id_rs1, id_rs2     : source operands of the instruction in ID
//   flush                        : branch/jump taken in EX
//   load_use                     : ID needs a value a load in EX has not produced
//   stall                        : freeze PC and IF/ID for one cycle
// ---------------------------------------------------------------------------
module hazard_detect
   import riscv_pipe_pkg::*;
(
   input  logic                 ex_valid,
   input  logic                 ex_mem_read,
   input  logic [REG_IDX_W-1:0] ex_rd,
   input  logic                 id_valid,
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   input  logic                 flush,
   output logic                 load_use,
   output logic                 stall
);

   logic rd_matches;

   // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
   assign rd_matches = (ex_rd == id_rs1) || (ex_rd == id_rs2);
   assign load_use   = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid && rd_matches;

   // A flush squashes the dependent instruction anyway, so stalling is pointless.
   assign stall      = load_use && !flush;

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use bubble insertion.
// Ports:
//   clk, rst (async, active-high)
//   Hold       : global freeze, every register keeps its value
//   Flush      : squash the instruction leaving ID (bubble loaded)
//   ID_Valid   : IF/ID holds a real instruction
//   IF_ID_PC, ID_RD1, ID_RD2, ID_Imm, IF_ID_RegRs1/Rs2/Rd, ID_Ctrl : ID inputs
//   ID_EX_*    : registered copies, one cycle later
//   Stall      : combinational, freezes PC and IF/ID on a load-use hazard
//   BubbleCnt  : bubble counter, present only when ID_EX_BUBBLE_CNT_EN is defined
// Priority on each edge: Hold > Flush > load-use > normal load.
// ---------------------------------------------------------------------------
module id_ex_stage
   import riscv_pipe_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 9
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              Hold,
   input  logic              Flush,
   input  logic              ID_Valid,
   input  logic [XLEN-1:0]   IF_ID_PC,
   input  logic [XLEN-1:0]   ID_RD1,
   input  logic [XLEN-1:0]   ID_RD2,
   input  logic [XLEN-1:0]   ID_Imm,
   input  logic [4:0]        IF_ID_RegRs1,
   input  logic [4:0]        IF_ID_RegRs2,
   input  logic [4:0]        IF_ID_RegRd,
   input  logic [CTRL_W-1:0] ID_Ctrl,
   output logic [XLEN-1:0]   ID_EX_PC,
   output logic [XLEN-1:0]   ID_EX_RD1,
   output logic [XLEN-1:0]   ID_EX_RD2,
   output logic [XLEN-1:0]   ID_EX_Imm,
   output logic [4:0]        ID_EX_RegRs1,
   output logic [4:0]        ID_EX_RegRs2,
   output logic [4:0]        ID_EX_RegRd,
   output logic [CTRL_W-1:0] ID_EX_Ctrl,
   output logic              ID_EX_Valid,
   output logic              Stall
`ifdef ID_EX_BUBBLE_CNT_EN
   ,
   output logic [31:0]       BubbleCnt
`endif
);

   localparam logic [CTRL_W-1:0] NOP_BITS = CTRL_W'(CTRL_NOP);

   logic ex_mem_read;
   logic load_use;
   logic take_bubble;

   assign ex_mem_read = ctrl_mem_read(ID_EX_Ctrl[riscv_pipe_pkg::CTRL_W-1:0]);
   assign take_bubble = Flush || load_use;

   hazard_detect u_hazard (
      .ex_valid    (ID_EX_Valid),
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ID_EX_RegRd),
      .id_valid    (ID_Valid),
      .id_rs1      (IF_ID_RegRs1),
      .id_rs2      (IF_ID_RegRs2),
      .flush       (Flush),
      .load_use    (load_use),
      .stall       (Stall)
   );

   // Pipeline register. A bubble zeroes every field so the forward unit never
   // sees stale indices; an invalid ID slot still loads data but cannot write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ID_EX_PC     <= '0;
         ID_EX_RD1    <= '0;
         ID_EX_RD2    <= '0;
         ID_EX_Imm    <= '0;
         ID_EX_RegRs1 <= '0;
         ID_EX_RegRs2 <= '0;
         ID_EX_RegRd  <= '0;
         ID_EX_Ctrl   <= NOP_BITS;
         ID_EX_Valid  <= 1'b0;
      end else if (!Hold) begin
         if (take_bubble) begin
            ID_EX_PC     <= '0;
            ID_EX_RD1    <= '0;
            ID_EX_RD2    <= '0;
            ID_EX_Imm    <= '0;
            ID_EX_RegRs1 <= '0;
            ID_EX_RegRs2 <= '0;
            ID_EX_RegRd  <= '0;
            ID_EX_Ctrl   <= NOP_BITS;
            ID_EX_Valid  <= 1'b0;
         end else begin
            ID_EX_PC     <= IF_ID_PC;
            ID_EX_RD1    <= ID_RD1;
            ID_EX_RD2    <= ID_RD2;
            ID_EX_Imm    <= ID_Imm;
            ID_EX_RegRs1 <= IF_ID_RegRs1;
            ID_EX_RegRs2 <= IF_ID_RegRs2;
            ID_EX_RegRd  <= ID_Valid ? IF_ID_RegRd : 5'd0;
            ID_EX_Ctrl   <= ID_Valid ? ID_Ctrl : NOP_BITS;
            ID_EX_Valid  <= ID_Valid;
         end
      end
   end

`ifdef ID_EX_BUBBLE_CNT_EN
   // Counts every bubble actually inserted; wraps naturally at 2^32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         BubbleCnt <= '0;
      end else if (!Hold && take_bubble) begin
         BubbleCnt <= BubbleCnt + 32'd1;
      end
   end
`else
   // Bubble counter not built; bubbles are inserted but not tallied.
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Self-checking bench for id_ex_stage. Inputs change on the falling edge and
// outputs are checked 1 ns later against a behavioural model of the stage.
// The bubble counter is exercised when ID_EX_BUBBLE_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

   localparam int XLEN = 32;
   localparam int CW   = 9;

   logic            clk = 1'b0;
   logic            rst;
   logic            Hold, Flush, ID_Valid;
   logic [XLEN-1:0] IF_ID_PC, ID_RD1, ID_RD2, ID_Imm;
   logic [4:0]      IF_ID_RegRs1, IF_ID_RegRs2, IF_ID_RegRd;
   logic [CW-1:0]   ID_Ctrl;
   logic [XLEN-1:0] ID_EX_PC, ID_EX_RD1, ID_EX_RD2, ID_EX_Imm;
   logic [4:0]      ID_EX_RegRs1, ID_EX_RegRs2, ID_EX_RegRd;
   logic [CW-1:0]   ID_EX_Ctrl;
   logic            ID_EX_Valid, Stall;
`ifdef ID_EX_BUBBLE_CNT_EN
   logic [31:0]     BubbleCnt;
`endif

   int vectors     = 0;
   int miscompares = 0;

   // Model of what the ID/EX register must currently hold.
   logic [XLEN-1:0] m_pc, m_rd1, m_rd2, m_imm;
   logic [4:0]      m_rs1, m_rs2, m_rd;
   logic [CW-1:0]   m_ctrl;
   logic            m_valid;
   logic [31:0]     m_cnt;

   localparam logic [CW-1:0] LW_CTRL  = 9'h1B0;
   localparam logic [CW-1:0] ADD_CTRL = 9'h100;

   id_ex_stage #(.XLEN(XLEN), .CTRL_W(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .Hold         (Hold),
      .Flush        (Flush),
      .ID_Valid     (ID_Valid),
      .IF_ID_PC     (IF_ID_PC),
      .ID_RD1       (ID_RD1),
      .ID_RD2       (ID_RD2),
      .ID_Imm       (ID_Imm),
      .IF_ID_RegRs1 (IF_ID_RegRs1),
      .IF_ID_RegRs2 (IF_ID_RegRs2),
      .IF_ID_RegRd  (IF_ID_RegRd),
      .ID_Ctrl      (ID_Ctrl),
      .ID_EX_PC     (ID_EX_PC),
      .ID_EX_RD1    (ID_EX_RD1),
      .ID_EX_RD2    (ID_EX_RD2),
      .ID_EX_Imm    (ID_EX_Imm),
      .ID_EX_RegRs1 (ID_EX_RegRs1),
      .ID_EX_RegRs2 (ID_EX_RegRs2),
      .ID_EX_RegRd  (ID_EX_RegRd),
      .ID_EX_Ctrl   (ID_EX_Ctrl),
      .ID_EX_Valid  (ID_EX_Valid),
      .Stall        (Stall)
`ifdef ID_EX_BUBBLE_CNT_EN
      ,
      .BubbleCnt    (BubbleCnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // An instruction in EX that is a valid load to a nonzero register blocks
   // any valid ID instruction reading that register.
   function automatic logic modelLoadUse();
      logic ex_is_load;
      ex_is_load = m_valid && m_ctrl[7] && (m_rd != 5'd0);
      return ex_is_load && ID_Valid && ((m_rd == IF_ID_RegRs1) || (m_rd == IF_ID_RegRs2));
   endfunction

   task automatic modelReset();
      m_pc = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
      m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_ctrl = '0; m_valid = 1'b0;
      m_cnt = '0;
   endtask

   // Advance the model by one clock edge using the inputs now applied.
   task automatic modelEdge();
      if (Hold) return;
      if (Flush || modelLoadUse()) begin
         m_pc = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
         m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_ctrl = '0; m_valid = 1'b0;
         m_cnt = m_cnt + 32'd1;
      end else begin
         m_pc = IF_ID_PC; m_rd1 = ID_RD1; m_rd2 = ID_RD2; m_imm = ID_Imm;
         m_rs1 = IF_ID_RegRs1; m_rs2 = IF_ID_RegRs2;
         m_valid = ID_Valid;
         m_rd   = ID_Valid ? IF_ID_RegRd : 5'd0;
         m_ctrl = ID_Valid ? ID_Ctrl : '0;
      end
   endtask

   task automatic checkOutput();
      cmp("pc",    ID_EX_PC,     m_pc);
      cmp("rd1",   ID_EX_RD1,    m_rd1);
      cmp("rd2",   ID_EX_RD2,    m_rd2);
      cmp("imm",   ID_EX_Imm,    m_imm);
      cmp("rs1",   ID_EX_RegRs1, m_rs1);
      cmp("rs2",   ID_EX_RegRs2, m_rs2);
      cmp("rd",    ID_EX_RegRd,  m_rd);
      cmp("ctrl",  ID_EX_Ctrl,   m_ctrl);
      cmp("valid", ID_EX_Valid,  m_valid);
      cmp("stall", Stall,        modelLoadUse() && !Flush);
`ifdef ID_EX_BUBBLE_CNT_EN
      cmp("bubble_cnt", BubbleCnt, m_cnt);
`endif
   endtask

   // Drive one cycle of ID inputs on the falling edge, check, then advance the model.
   task automatic applyStimulus(input logic hold, input logic flush, input logic valid,
                                input logic [31:0] pc, input logic [31:0] rd1,
                                input logic [31:0] rd2, input logic [31:0] imm,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [8:0] ctrl);
      @(negedge clk);
      Hold = hold; Flush = flush; ID_Valid = valid;
      IF_ID_PC = pc; ID_RD1 = rd1; ID_RD2 = rd2; ID_Imm = imm;
      IF_ID_RegRs1 = rs1; IF_ID_RegRs2 = rs2; IF_ID_RegRd = rd; ID_Ctrl = ctrl;
      #1;
      checkOutput();
      modelEdge();
   endtask

   // Reset pulse strictly between clock edges; outputs must clear at once.
   task automatic resetPulse();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      modelReset();
      checkOutput();
      cmp("rst_ctrl_lit", ID_EX_Ctrl, 9'h000);
      cmp("rst_valid_lit", ID_EX_Valid, 1'b0);
      rst = 1'b0;
      modelEdge();
   endtask

   initial begin
      rst = 1'b1;
      Hold = 0; Flush = 0; ID_Valid = 0;
      IF_ID_PC = '0; ID_RD1 = '0; ID_RD2 = '0; ID_Imm = '0;
      IF_ID_RegRs1 = '0; IF_ID_RegRs2 = '0; IF_ID_RegRd = '0; ID_Ctrl = '0;
      modelReset();
      @(negedge clk);
      #1;
      checkOutput();
      cmp("reset_valid_lit", ID_EX_Valid, 1'b0);
      rst = 1'b0;
      modelEdge();

      // lw x5 then dependent add x6,x5,x7: one stall cycle, bubble, then add.
      applyStimulus(0, 0, 1, 32'h100, 32'h11, 32'h22, 32'h4, 5'd1, 5'd0, 5'd5, LW_CTRL);
      applyStimulus(0, 0, 1, 32'h104, 32'h33, 32'h44, 32'h0, 5'd5, 5'd7, 5'd6, ADD_CTRL);
      cmp("lu_stall_lit", Stall, 1'b1);
      applyStimulus(0, 0, 1, 32'h104, 32'h33, 32'h44, 32'h0, 5'd5, 5'd7, 5'd6, ADD_CTRL);
      cmp("lu_bubble_valid_lit", ID_EX_Valid, 1'b0);
      cmp("lu_bubble_ctrl_lit", ID_EX_Ctrl, 9'h000);
      cmp("lu_stall_once_lit", Stall, 1'b0);
      applyStimulus(0, 0, 0, 32'h108, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 9'h000);
      cmp("lu_add_rs1_lit", ID_EX_RegRs1, 5'd5);
      cmp("lu_add_rd_lit", ID_EX_RegRd, 5'd6);
      cmp("lu_add_valid_lit", ID_EX_Valid, 1'b1);

      // Same hazard with Flush: no stall, bubble loaded anyway.
      applyStimulus(0, 0, 1, 32'h200, 32'h1, 32'h2, 32'h8, 5'd2, 5'd0, 5'd5, LW_CTRL);
      applyStimulus(0, 1, 1, 32'h204, 32'h3, 32'h4, 32'h0, 5'd5, 5'd7, 5'd6, ADD_CTRL);
      cmp("flush_stall_lit", Stall, 1'b0);
      applyStimulus(0, 0, 0, 32'h208, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 9'h000);
      cmp("flush_valid_lit", ID_EX_Valid, 1'b0);

      // Load to x0 never stalls a reader of x0.
      applyStimulus(0, 0, 1, 32'h300, 32'h1, 32'h2, 32'h0, 5'd1, 5'd0, 5'd0, LW_CTRL);
      applyStimulus(0, 0, 1, 32'h304, 32'h5, 32'h6, 32'h0, 5'd0, 5'd3, 5'd4, ADD_CTRL);
      cmp("x0_stall_lit", Stall, 1'b0);
      applyStimulus(0, 0, 0, 32'h308, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 9'h000);
      cmp("x0_valid_lit", ID_EX_Valid, 1'b1);
      cmp("x0_rd_lit", ID_EX_RegRd, 5'd4);

      // Hold for three cycles with changing inputs, then resume.
      applyStimulus(0, 0, 1, 32'h1234, 32'h9, 32'h8, 32'h7, 5'd1, 5'd2, 5'd9, ADD_CTRL);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, i == 1, 1, $urandom, $urandom, $urandom, $urandom,
                       5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                       5'($urandom_range(0, 31)), 9'($urandom));
         cmp("hold_pc_lit", ID_EX_PC, 32'h1234);
      end
      applyStimulus(0, 0, 1, 32'h5678, 32'h1, 32'h1, 32'h1, 5'd3, 5'd4, 5'd10, ADD_CTRL);
      applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 9'h000);
      cmp("resume_pc_lit", ID_EX_PC, 32'h5678);

      // Reset pulse while a RegW instruction sits in ID/EX.
      applyStimulus(0, 0, 1, 32'h400, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, ADD_CTRL);
      resetPulse();

`ifdef ID_EX_BUBBLE_CNT_EN
      // Preset the counter to its maximum, then one bubble must wrap it to zero.
      applyStimulus(1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 9'h000);
      force dut.BubbleCnt = 32'hFFFF_FFFF;
      #1;
      release dut.BubbleCnt;
      m_cnt = 32'hFFFF_FFFF;
      applyStimulus(0, 1, 1, 32'h500, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3, ADD_CTRL);
      applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 9'h000);
      cmp("cnt_wrap_lit", BubbleCnt, 32'h0);
`endif

      // Randomized stream; small register range makes hazards frequent.
      for (int i = 0; i < 2000; i++) begin
         applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                       $urandom_range(0, 4) != 0,
                       $urandom, $urandom, $urandom, $urandom,
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)), 9'($urandom));
      end

      applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 9'h000);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter CTRL_W, default 9, width of control bundle (field layout in pkg).
REQ-003 SHALL have port clk  input  1  single rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port Hold  input  1  global freeze (memory stall); all state held.
REQ-006 SHALL have port Flush  input  1  branch/jump taken in EX; squash instruction in ID.
REQ-007 SHALL have port ID_Valid  input  1  IF/ID holds a real instruction.
REQ-008 SHALL have ports IF_ID_PC, ID_RD1, ID_RD2, ID_Imm  input  XLEN  PC, rs1 data, rs2 data, immediate.
REQ-009 SHALL have ports IF_ID_RegRs1, IF_ID_RegRs2, IF_ID_RegRd  input  5  register indices.
REQ-010 SHALL have port ID_Ctrl  input  CTRL_W  {RegW, MemRead, MemWrite, MemToReg, ALUSrc, ALUOp[3:0]}.
REQ-011 SHALL have outputs ID_EX_PC, ID_EX_RD1, ID_EX_RD2, ID_EX_Imm  output  XLEN  registered copies.
REQ-012 SHALL have outputs ID_EX_RegRs1, ID_EX_RegRs2, ID_EX_RegRd  output  5  registered indices (to forward unit).
REQ-013 SHALL have outputs ID_EX_Ctrl  output  CTRL_W, ID_EX_Valid  output  1.
REQ-014 SHALL have output Stall  output  1  combinational; freezes PC and IF/ID.

Function
REQ-015 SHALL compute LoadUse = ID_EX_Valid & ID_EX_Ctrl.MemRead & (ID_EX_RegRd!=0) & ID_Valid & (ID_EX_RegRd==IF_ID_RegRs1 | ID_EX_RegRd==IF_ID_RegRs2).
REQ-016 SHALL drive Stall = LoadUse & ~Flush (flush squashes the dependent instruction; no stall needed).
REQ-017 SHALL apply per-edge priority: Hold > Flush > LoadUse > load.
REQ-018 Hold=1: every register, including counter, SHALL keep its value; Stall still computed per REQ-016.
REQ-019 Flush=1 or LoadUse=1 (Hold=0): SHALL load a bubble: ID_EX_Ctrl=0, ID_EX_Valid=0, ID_EX_RegRd=0, ID_EX_RegRs1/Rs2=0; data fields don't-care but SHALL be zeroed.
REQ-020 Otherwise SHALL load all ID inputs; ID_EX_Valid=ID_Valid; if ID_Valid=0, Ctrl and RegRd SHALL be forced 0.
REQ-021 Latency: exactly one cycle from ID inputs to ID_EX outputs.
REQ-022 A load-use stall SHALL last exactly one cycle (the bubble clears MemRead); back-to-back loads each stall independently.
REQ-023 Rd=x0 on a load SHALL never cause Stall.

Reset
REQ-024 rst=1 SHALL asynchronously clear all registered outputs to 0 (ID_EX_Valid=0) and the bubble counter to 0; Stall then evaluates 0.
REQ-025 Reset deassertion SHALL take effect on the next clk edge with no extra cycles.

Configuration
REQ-026 With ID_EX_BUBBLE_CNT_EN defined: SHALL add output BubbleCnt [31:0], incremented (wrapping at 2^32-1 to 0) on each edge where a bubble is loaded with Hold=0.
REQ-027 Without ID_EX_BUBBLE_CNT_EN: port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-028 Package riscv_pipe_pkg SHALL hold the ctrl_t packed struct, CTRL_W, and a CTRL_NOP=0 constant.
REQ-029 Sub-module hazard_detect SHALL implement the combinational LoadUse/Stall logic; id_ex_stage instantiates it.

Verification
REQ-030 lw x5 in EX, add x6,x5,x7 in ID -> Stall=1 one cycle, next ID_EX_Valid=0, Ctrl=0; following cycle add loaded with RegRs1=5.
REQ-031 Same as REQ-030 but Flush=1 -> Stall=0, bubble loaded, BubbleCnt +1.
REQ-032 lw x0 in EX, dependent rs1=0 in ID -> Stall=0, normal load.
REQ-033 Hold=1 for 3 cycles mid-stream, inputs changing -> outputs and BubbleCnt unchanged; resume loads current inputs.
REQ-034 rst pulse between edges with ID_EX_Ctrl.RegW=1 -> all outputs 0 immediately, before next edge.
REQ-035 BubbleCnt preset via 2^32-1 bubbles (force) + one bubble -> BubbleCnt=0.
